// File: rtl/ejector.sv
// ejector: removes flits addressed to this node from the four mesh links into a FIFO for the core.
// Optional ej_count/miss_count statistics are built only when EJECTOR_STATS_EN is defined.
module ejector #(
  parameter logic [2:0] MY_ROW = 3'd4,
  parameter logic [2:0] MY_COL = 3'd4,
  parameter int         DEPTH  = 4,
  parameter int         EJ_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  eastad,
  input  logic [9:0]  westad,
  input  logic [9:0]  northad,
  input  logic [9:0]  southad,
  output logic [9:0]  ead,
  output logic [9:0]  wad,
  output logic [9:0]  nad,
  output logic [9:0]  sad,
  output logic [9:0]  localad,
  output logic        local_valid,
  input  logic        local_ready
`ifdef EJECTOR_STATS_EN
  ,
  output logic [15:0] ej_count,
  output logic [15:0] miss_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [9:0]    in_s    [4];
  logic [9:0]    next_s  [4];
  logic [PW-1:0] waddr_s [4];
  logic [3:0]    grant_s;
  logic [4:0]    room_s;
  logic [4:0]    limit_s;
  logic [4:0]    taken_s;
  logic          pop_s;

  logic [9:0]    mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  function automatic logic is_local(input logic v, input logic [2:0] row, input logic [2:0] col);
    is_local = v && (row == MY_ROW) && (col == MY_COL);
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {12'b0, b};
    sat_add = s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Grant scan: room is taken from the start-of-cycle occupancy, so a same-cycle pop frees nothing.
  always_comb begin
    in_s[0] = eastad;
    in_s[1] = westad;
    in_s[2] = northad;
    in_s[3] = southad;
    room_s  = 5'(DEPTH) - 5'(count_r);
    limit_s = (room_s < 5'(EJ_MAX)) ? room_s : 5'(EJ_MAX);
    taken_s = 5'd0;
    for (int i = 0; i < 4; i++) begin
      waddr_s[i] = wr_ptr_r + PW'(taken_s);
      if (is_local(in_s[i][9], in_s[i][5:3], in_s[i][2:0]) && (taken_s < limit_s)) begin
        grant_s[i] = 1'b1;
        taken_s    = taken_s + 5'd1;
      end else begin
        grant_s[i] = 1'b0;
      end
      if (grant_s[i] || !in_s[i][9]) begin
        next_s[i] = 10'b0;
      end else begin
        next_s[i] = in_s[i];
      end
    end
  end

  assign pop_s       = local_valid && local_ready;
  assign local_valid = (count_r != CW'(0));
  assign localad     = local_valid ? mem_r[rd_ptr_r] : 10'b0;

  // Link output registers and FIFO pointer/occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ead      <= 10'b0;
      wad      <= 10'b0;
      nad      <= 10'b0;
      sad      <= 10'b0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      ead      <= next_s[0];
      wad      <= next_s[1];
      nad      <= next_s[2];
      sad      <= next_s[3];
      rd_ptr_r <= rd_ptr_r + PW'(pop_s);
      wr_ptr_r <= wr_ptr_r + PW'(taken_s);
      count_r  <= count_r + CW'(taken_s) - CW'(pop_s);
    end
  end

  // FIFO storage: granted flits land at consecutive slots in scan order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 10'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (grant_s[i]) begin
          mem_r[waddr_s[i]] <= in_s[i];
        end
      end
    end
  end

`ifdef EJECTOR_STATS_EN
  logic [4:0] locals_s;

  // Count every local flit seen this cycle; misses are the ones left ungranted.
  always_comb begin
    locals_s = 5'd0;
    for (int i = 0; i < 4; i++) begin
      if (is_local(in_s[i][9], in_s[i][5:3], in_s[i][2:0])) begin
        locals_s = locals_s + 5'd1;
      end else begin
        locals_s = locals_s;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ej_count   <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      ej_count   <= sat_add(ej_count, taken_s);
      miss_count <= sat_add(miss_count, locals_s - taken_s);
    end
  end
`endif

endmodule

// File: tb/tb_ejector.sv
// Randomized self-checking bench for ejector: queue-based reference model plus directed test-plan cases.
module tb_ejector;
  localparam int DEPTH  = 4;
  localparam int EJ_MAX = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] eastad, westad, northad, southad;
  logic [9:0] ead, wad, nad, sad, localad;
  logic       local_valid;
  logic       local_ready;
`ifdef EJECTOR_STATS_EN
  logic [15:0] ej_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [9:0] q[$];
  logic [9:0] exp_link [4];
  int         exp_ej   = 0;
  int         exp_miss = 0;

  ejector #(.MY_ROW(3'd4), .MY_COL(3'd4), .DEPTH(DEPTH), .EJ_MAX(EJ_MAX)) dut (
    .clk(clk), .rst(rst),
    .eastad(eastad), .westad(westad), .northad(northad), .southad(southad),
    .ead(ead), .wad(wad), .nad(nad), .sad(sad),
    .localad(localad), .local_valid(local_valid), .local_ready(local_ready)
`ifdef EJECTOR_STATS_EN
    , .ej_count(ej_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: compute what the next edge must produce from the current inputs and queue.
  task automatic model_edge();
    logic [9:0] ins [4];
    int room, lim, n, loc;
    bit islocal;
    ins[0] = eastad; ins[1] = westad; ins[2] = northad; ins[3] = southad;
    room = DEPTH - q.size();
    lim  = (room < EJ_MAX) ? room : EJ_MAX;
    n = 0; loc = 0;
    if (q.size() > 0 && local_ready) void'(q.pop_front());
    for (int i = 0; i < 4; i++) begin
      islocal = ins[i][9] && (ins[i][5:3] == 3'd4) && (ins[i][2:0] == 3'd4);
      if (islocal) loc++;
      if (islocal && n < lim) begin
        q.push_back(ins[i]);
        n++;
        exp_link[i] = 10'b0;
      end else begin
        exp_link[i] = ins[i][9] ? ins[i] : 10'b0;
      end
    end
    exp_ej   = (exp_ej + n > 65535) ? 65535 : exp_ej + n;
    exp_miss = (exp_miss + loc - n > 65535) ? 65535 : exp_miss + loc - n;
  endtask

  task automatic compare_all();
    chk("ead", ead, exp_link[0]);
    chk("wad", wad, exp_link[1]);
    chk("nad", nad, exp_link[2]);
    chk("sad", sad, exp_link[3]);
    chk("local_valid", local_valid, (q.size() != 0));
    chk("localad", localad, (q.size() != 0) ? q[0] : 10'b0);
`ifdef EJECTOR_STATS_EN
    chk("ej_count", ej_count, exp_ej[15:0]);
    chk("miss_count", miss_count, exp_miss[15:0]);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [9:0] e, input logic [9:0] w, input logic [9:0] n, input logic [9:0] s,
                       input logic rdy);
    eastad = e; westad = w; northad = n; southad = s; local_ready = rdy;
  endtask

  task automatic drain();
    drive(10'h0, 10'h0, 10'h0, 10'h0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step();
  endtask

  function automatic logic [9:0] rflit();
    logic [2:0] row, col, dir;
    logic v;
    v   = ($urandom_range(0, 3) != 0);
    dir = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) begin
      row = 3'd4; col = 3'd4;
    end else begin
      row = 3'($urandom_range(0, 7)); col = 3'($urandom_range(0, 7));
    end
    return {v, dir, row, col};
  endfunction

  task automatic reset_model();
    q.delete();
    for (int i = 0; i < 4; i++) exp_link[i] = 10'b0;
    exp_ej = 0; exp_miss = 0;
  endtask

  initial begin
    rst = 1'b1;
    drive(10'h0, 10'h0, 10'h0, 10'h0, 1'b0);
    reset_model();
    #12;
    compare_all();
    chk("reset_valid", local_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single eject
    drive(10'h324, 10'h0, 10'h0, 10'h0, 1'b1);
    step();
    chk("single_ead", ead, 10'h000);
    chk("single_localad", localad, 10'h324);
    chk("single_valid", local_valid, 1'b1);
    drive(10'h0, 10'h0, 10'h0, 10'h0, 1'b1);
    step();
    chk("single_valid_after", local_valid, 1'b0);

    // Pass-through of non-local flits
    drive(10'h22A, 10'h22A, 10'h22A, 10'h22A, 1'b1);
    step();
    chk("pass_ead", ead, 10'h22A);
    chk("pass_sad", sad, 10'h22A);
    chk("pass_valid", local_valid, 1'b0);

    // EJ_MAX limit: first two in scan order are taken
    drive(10'h324, 10'h324, 10'h324, 10'h324, 1'b0);
    step();
    chk("ejmax_ead", ead, 10'h000);
    chk("ejmax_wad", wad, 10'h000);
    chk("ejmax_nad", nad, 10'h324);
    chk("ejmax_sad", sad, 10'h324);
    chk("ejmax_model_cnt", 16'(q.size()), 16'd2);
    drain();

    // Full FIFO with the core stalled
    for (int c = 0; c < 6; c++) begin
      drive(10'h324, 10'h0, 10'h0, 10'h0, 1'b0);
      step();
      if (c >= 4) chk("full_deflect_ead", ead, 10'h324);
    end
    chk("full_model_cnt", 16'(q.size()), 16'd4);
    drive(10'h0, 10'h0, 10'h0, 10'h0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      chk("full_drain_valid", local_valid, 1'b1);
      step();
    end
    chk("full_drained", local_valid, 1'b0);

    // Push and pop together at full: this cycle deflects, next cycle accepts
    for (int c = 0; c < 4; c++) begin
      drive(10'h324, 10'h0, 10'h0, 10'h0, 1'b0);
      step();
    end
    drive(10'h324, 10'h0, 10'h0, 10'h0, 1'b1);
    step();
    chk("pp_deflect", ead, 10'h324);
    step();
    chk("pp_accept", ead, 10'h000);
    drain();

    // Asynchronous reset with three queued flits
    for (int c = 0; c < 3; c++) begin
      drive(10'h324, 10'h0, 10'h0, 10'h0, 1'b0);
      step();
    end
    chk("prereset_valid", local_valid, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    reset_model();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    drive(10'h0, 10'h0, 10'h0, 10'h0, 1'b1);
    #1;
    chk("postreset_valid", local_valid, 1'b0);
    drive(10'h324, 10'h0, 10'h0, 10'h0, 1'b1);
    step();
    chk("postreset_localad", localad, 10'h324);
    chk("postreset_lvalid", local_valid, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive(rflit(), rflit(), rflit(), rflit(), ($urandom_range(0, 2) != 0));
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
